// File: rtl/krnl_proj_split_deadlock_pkg.sv
// Shared types and field constants for the deadlock report unit.
// DEADLOCK_REPORT_TIMESTAMP_EN adds a 32-bit timestamp field to the report word.
package krnl_proj_split_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEND  = 2'd2,
    ST_HOLD  = 2'd3
  } dl_state_e;

  localparam logic [7:0] EVENT_CNT_MAX = 8'hFF;
  localparam int         EVENT_IDX_W   = 8;
  localparam int         TS_W          = 32;

  // Default field widths of the monitor/status snapshot.
  localparam int DEF_NUM_MON = 2;
  localparam int DEF_AXIS_W  = 3;
  localparam int DEF_IDLE_W  = 9;
  localparam int DEF_BLK_W   = 5;

`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
  localparam int TS_FIELD_W = TS_W;
`else
  localparam int TS_FIELD_W = 0;
`endif

  function automatic int report_w(input int nm, input int aw, input int iw, input int bw);
    return TS_FIELD_W + EVENT_IDX_W + nm + aw + iw + bw;
  endfunction

endpackage

// File: rtl/krnl_proj_split_deadlock_persist_ctr.sv
// Consecutive-cycle counter: hit is high on the CONFIRM_CYCLES-th consecutive cycle of en.
module krnl_proj_split_deadlock_persist_ctr #(
  parameter int CONFIRM_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int            CW   = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CONFIRM_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit = en && (cnt_q == LAST);

  // Any gap in en restarts the run; the count parks at LAST once hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) cnt_d = '0;
    else if (!hit)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/krnl_proj_split_hls_deadlock_report_unit.sv
// Confirms persistent monitor blocks and emits one snapshot report per block episode.
// Define DEADLOCK_REPORT_TIMESTAMP_EN to prepend a free-running 32-bit cycle stamp.
module krnl_proj_split_hls_deadlock_report_unit
  import krnl_proj_split_deadlock_pkg::*;
#(
  parameter int NUM_MON        = DEF_NUM_MON,
  parameter int AXIS_W         = DEF_AXIS_W,
  parameter int IDLE_W         = DEF_IDLE_W,
  parameter int BLK_W          = DEF_BLK_W,
  parameter int CONFIRM_CYCLES = 16,
  localparam int REPORT_W      = report_w(NUM_MON, AXIS_W, IDLE_W, BLK_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_MON-1:0]  monitor_block,
  input  logic [AXIS_W-1:0]   axis_block_sigs,
  input  logic [IDLE_W-1:0]   inst_idle_sigs,
  input  logic [BLK_W-1:0]    inst_block_sigs,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [REPORT_W-1:0] rpt_data,
  output logic                deadlock_sticky,
  output logic [7:0]          event_count
);

  dl_state_e           state_q, state_d;
  logic                any_block, ctr_en, hit, declare;
  logic                sticky_q;
  logic [7:0]          count_q, count_inc;
  logic [REPORT_W-1:0] data_q, snap;

  assign any_block = |monitor_block;
  assign ctr_en    = any_block && (state_q == ST_IDLE || state_q == ST_ARMED);

  krnl_proj_split_deadlock_persist_ctr #(
    .CONFIRM_CYCLES(CONFIRM_CYCLES)
  ) u_persist (
    .clock(clock),
    .reset(reset),
    .clr  (clear),
    .en   (ctr_en),
    .hit  (hit)
  );

  assign count_inc = (count_q == EVENT_CNT_MAX) ? count_q : count_q + 8'd1;

`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running; deliberately immune to clear so stamps stay monotonic.
  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign snap = {ts_q, count_inc, monitor_block, axis_block_sigs, inst_idle_sigs, inst_block_sigs};
`else
  assign snap = {count_inc, monitor_block, axis_block_sigs, inst_idle_sigs, inst_block_sigs};
`endif

  always_comb begin
    state_d = state_q;
    declare = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (hit) begin
          declare = 1'b1;
          state_d = ST_SEND;
        end else if (any_block) state_d = ST_ARMED;
        else                    state_d = ST_IDLE;
      end
      ST_SEND: if (rpt_ready)  state_d = ST_HOLD;
      ST_HOLD: if (!any_block) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    // Clear beats a same-cycle declare: nothing is counted or reported.
    if (clear) begin
      state_d = ST_IDLE;
      declare = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
      data_q   <= '0;
    end else if (clear) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (declare) begin
      sticky_q <= 1'b1;
      count_q  <= count_inc;
      data_q   <= snap;
    end
  end

  assign rpt_valid       = (state_q == ST_SEND);
  assign rpt_data        = data_q;
  assign deadlock_sticky = sticky_q;
  assign event_count     = count_q;

endmodule

// File: tb/tb_krnl_proj_split_hls_deadlock_report_unit.sv
// Directed bench with a report scoreboard for the deadlock report unit.
module tb_krnl_proj_split_hls_deadlock_report_unit;

  localparam int C = 16;
`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
  localparam int RW = 59;
`else
  localparam int RW = 27;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mb;
  logic [2:0]    axis;
  logic [8:0]    idle;
  logic [4:0]    blk;
  logic          clear;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [RW-1:0] rpt_data;
  logic          sticky;
  logic [7:0]    count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_e;
  logic [63:0] bp_exp;

  always #5 clock = ~clock;

  krnl_proj_split_hls_deadlock_report_unit #(.CONFIRM_CYCLES(C)) dut (
    .clock          (clock),
    .reset          (reset),
    .monitor_block  (mb),
    .axis_block_sigs(axis),
    .inst_idle_sigs (idle),
    .inst_block_sigs(blk),
    .clear          (clear),
    .rpt_valid      (rpt_valid),
    .rpt_ready      (rpt_ready),
    .rpt_data       (rpt_data),
    .deadlock_sticky(sticky),
    .event_count    (count)
  );

`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
  logic [31:0] tb_cyc;
  always @(posedge clock) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected report for an episode whose first blocked cycle is the next edge.
  function automatic logic [63:0] mk(input logic [7:0] idx);
`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
    return 64'({tb_cyc + 32'(C - 1), idx, mb, axis, idle, blk});
`else
    return 64'({idx, mb, axis, idle, blk});
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_report", 64'(rpt_data), 64'hDEAD);
      else begin
        sb_e = sb.pop_front();
        chk("report_word", 64'(rpt_data), sb_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mb = '0; axis = '0; idle = '0; blk = '0; clear = 1'b0; rpt_ready = 1'b1;
    step(3);
    reset = 1'b0;
    chk("reset_valid",  64'(rpt_valid), 64'd0);
    chk("reset_data",   64'(rpt_data),  64'd0);
    chk("reset_sticky", 64'(sticky),    64'd0);
    chk("reset_count",  64'(count),     64'd0);
    step(2);

    // Latency: report visible exactly C cycles after the first blocked cycle.
    axis = 3'b001; idle = 9'h1FF; blk = 5'h11; mb = 2'b01;
    sb.push_back(mk(8'd1));
    step(C - 1);
    chk("lat_early", 64'(rpt_valid), 64'd0);
    step(1);
    chk("lat_valid",  64'(rpt_valid), 64'd1);
    chk("lat_sticky", 64'(sticky),    64'd1);
    chk("lat_count",  64'(count),     64'd1);
    step(6);
    chk("hold_no_second", 64'(rpt_valid), 64'd0);
    mb = '0;
    step(2);

    // Glitch: a one-cycle gap restarts confirmation.
    mb = 2'b10;
    step(C - 1);
    mb = '0;
    step(1);
    mb = 2'b10;
    sb.push_back(mk(8'd2));
    step(C - 1);
    chk("glitch_early", 64'(rpt_valid), 64'd0);
    step(1);
    chk("glitch_valid", 64'(rpt_valid), 64'd1);
    step(1);
    mb = '0;
    step(2);
    chk("glitch_count", 64'(count), 64'd2);

    // Backpressure with snapshot pattern; inputs change after declare.
    rpt_ready = 1'b0;
    axis = 3'b101; idle = 9'h0F0; blk = 5'h0A; mb = 2'b11;
    bp_exp = mk(8'd3);
    sb.push_back(bp_exp);
    step(C);
    axis = 3'b010; idle = '0; blk = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(rpt_valid), 64'd1);
      chk("bp_data",  64'(rpt_data),  bp_exp);
      step(1);
    end
    rpt_ready = 1'b1;
    step(1);
    step(20);
    chk("bp_no_second", 64'(rpt_valid), 64'd0);
    chk("bp_count",     64'(count),     64'd3);
    mb = '0;
    step(2);

    // Clear on the declare cycle.
    mb = 2'b01;
    step(C - 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0; mb = '0;
    chk("clr_decl_valid",  64'(rpt_valid), 64'd0);
    chk("clr_decl_count",  64'(count),     64'd0);
    chk("clr_decl_sticky", 64'(sticky),    64'd0);
    step(1);
    chk("clr_decl_valid2", 64'(rpt_valid), 64'd0);

    // Clear during SEND aborts the pending report.
    rpt_ready = 1'b0; mb = 2'b01;
    step(C);
    chk("clr_send_pre",   64'(rpt_valid), 64'd1);
    chk("clr_send_cnt1",  64'(count),     64'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0; mb = '0;
    chk("clr_send_valid", 64'(rpt_valid), 64'd0);
    chk("clr_send_count", 64'(count),     64'd0);
    rpt_ready = 1'b1;
    step(2);

    // Reset during SEND loses the report.
    rpt_ready = 1'b0; mb = 2'b01;
    step(C);
    chk("rst_send_pre", 64'(rpt_valid), 64'd1);
    reset = 1'b1;
    step(1);
    chk("rst_send_valid", 64'(rpt_valid), 64'd0);
    chk("rst_send_data",  64'(rpt_data),  64'd0);
    reset = 1'b0; mb = '0; rpt_ready = 1'b1;
    step(2);

    // Saturation over 300 episodes with varied snapshots.
    for (int i = 1; i <= 300; i++) begin
      axis = 3'($urandom); idle = 9'($urandom); blk = 5'($urandom);
      mb = 2'($urandom_range(1, 3));
      sb.push_back(mk((i > 255) ? 8'd255 : 8'(i)));
      step(C + 1);
      mb = '0;
      step(1);
    end
    chk("sat_count",  64'(count),  64'd255);
    chk("sat_sticky", 64'(sticky), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("sat_clr_count",  64'(count),  64'd0);
    chk("sat_clr_sticky", 64'(sticky), 64'd0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
